// File: rtl/kyber_ram_pkg.sv
// Shared constants and types for the Kyber coefficient RAM: command codes,
// sequencer states and default geometry.
package kyber_ram_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 8;

  localparam logic CMD_CLEAR = 1'b0;
  localparam logic CMD_DUMP  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    DUMP,
    DRAIN,
    FIN
  } state_t;

endpackage

// File: rtl/kyber_ram_bank.sv
// Read-first true-dual-port storage with registered, enable-gated read data.
// Port A overrides port B when both write the same address.
module kyber_ram_bank
  import kyber_ram_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] dout_a,
  input  logic              re_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_b
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Port A write is ordered last so it takes precedence on an address clash.
  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= din_b;
    if (we_a) mem[addr_a] <= din_a;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_a <= '0;
      dout_b <= '0;
    end else begin
      if (re_a) dout_a <= mem[addr_a];
      if (re_b) dout_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/kyber_poly_ram.sv
// Dual-port polynomial coefficient RAM with CLEAR/DUMP sweep sequencer.
// Optional sticky same-address write flag: define KYBER_RAM_COLLISION_EN.
module kyber_poly_ram
  import kyber_ram_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic              we_1,
  input  logic [DATA_W-1:0] din_1,
  output logic [DATA_W-1:0] dout_1,
  input  logic [ADDR_W-1:0] addr_2,
  input  logic              we_2,
  input  logic [DATA_W-1:0] din_2,
  output logic [DATA_W-1:0] dout_2,
  input  logic              start,
  input  logic              cmd,
  output logic              busy,
  output logic              dump_valid,
  output logic              done
`ifdef KYBER_RAM_COLLISION_EN
  ,
  output logic              collision
`endif
);

  state_t            state, state_nx;
  logic [ADDR_W-2:0] k;
  logic              re_a, we_a, re_b, we_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] din_a, din_b;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Pair counter wraps to zero by overflow on the last pair.
  always_ff @(posedge clk) begin
    if (reset)                              k <= '0;
    else if (state == CLEAR || state == DUMP) k <= k + 1'b1;
    else                                    k <= '0;
  end

  always_ff @(posedge clk) begin
    if (reset) dump_valid <= 1'b0;
    else       dump_valid <= (state == DUMP);
  end

  always_comb begin
    state_nx = state;
    re_a     = 1'b0;
    we_a     = 1'b0;
    re_b     = 1'b0;
    we_b     = 1'b0;
    addr_a   = {k, 1'b0};
    addr_b   = {k, 1'b1};
    din_a    = '0;
    din_b    = '0;
    unique case (state)
      IDLE: begin
        re_a   = 1'b1;
        we_a   = we_1;
        addr_a = addr_1;
        din_a  = din_1;
        re_b   = 1'b1;
        we_b   = we_2;
        addr_b = addr_2;
        din_b  = din_2;
        if (start) state_nx = (cmd == CMD_DUMP) ? DUMP : CLEAR;
      end
      CLEAR: begin
        we_a = 1'b1;
        we_b = 1'b1;
        if (&k) state_nx = FIN;
      end
      DUMP: begin
        re_a = 1'b1;
        re_b = 1'b1;
        if (&k) state_nx = DRAIN;
      end
      DRAIN:   state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == CLEAR) || (state == DUMP) || (state == DRAIN);
  assign done = (state == FIN);

`ifdef KYBER_RAM_COLLISION_EN
  always_ff @(posedge clk) begin
    if (reset) collision <= 1'b0;
    else if (state == IDLE && we_1 && we_2 && addr_1 == addr_2) collision <= 1'b1;
  end
`endif

  kyber_ram_bank #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_bank (
    .clk   (clk),
    .rst   (reset),
    .re_a  (re_a),
    .we_a  (we_a),
    .addr_a(addr_a),
    .din_a (din_a),
    .dout_a(dout_1),
    .re_b  (re_b),
    .we_b  (we_b),
    .addr_b(addr_b),
    .din_b (din_b),
    .dout_b(dout_2)
  );

endmodule

// File: doc/kyber_poly_ram.md
Name: kyber_poly_ram

Overview:
Parametrised true-dual-port coefficient RAM for polynomial storage in the Kyber NTT datapath. Default size is 256 x 16 signed. Adds explicit addressing per port and an internal sweep sequencer with two commands, CLEAR (zero-fill) and DUMP (stream all coefficients as even/odd pairs), signalled by busy/done. Sits between the NTT butterfly unit and the I/O loader.

Parameters:
DATA_W, 16, coefficient width (signed)
ADDR_W, 8, address width; DEPTH = 2**ADDR_W (must be even, >= 4)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
addr_1  in  ADDR_W  port 1 address
we_1  in  1  port 1 write enable
din_1  in  DATA_W  port 1 write data
dout_1  out  DATA_W  port 1 registered read data
addr_2  in  ADDR_W  port 2 address
we_2  in  1  port 2 write enable
din_2  in  DATA_W  port 2 write data
dout_2  out  DATA_W  port 2 registered read data
start  in  1  command strobe, sampled only when busy=0
cmd  in  1  0 = CLEAR, 1 = DUMP
busy  out  1  sequencer active
dump_valid  out  1  dout_1/dout_2 carry a DUMP pair
done  out  1  one-cycle pulse at command completion

Behaviour:
- Reset values: dout_1 = dout_2 = 0, busy = 0, dump_valid = 0, done = 0, FSM = IDLE, counter = 0. Memory contents are not cleared by reset.
- IDLE: each port is read-first. dout_n <= mem[addr_n] (old value) every cycle. If we_n, mem[addr_n] <= din_n. Read latency is 1 cycle.
- Both ports write the same address in the same cycle: port 1 wins.
- One port writes while the other reads the same address: the reader gets the old data.
- FSM states: IDLE, CLEAR, DUMP, DRAIN, FIN.
- Command acceptance: start=1 in IDLE at edge T moves the FSM to CLEAR or DUMP per cmd. busy=1 from cycle T+1. start while busy is ignored.
- While busy, external we_n and addr_n are ignored; the sequencer owns both ports.
- Pair counter k runs 0..DEPTH/2-1 (ADDR_W-1 bits). Port 1 addresses 2k, port 2 addresses 2k+1.
- CLEAR: writes 0 to both addresses every cycle. After k = DEPTH/2-1 it goes to FIN. dout_n holds its last value.
- DUMP: reads both addresses every cycle. dump_valid=1 exactly one cycle after each read, so DEPTH/2 consecutive valid cycles. After the last read it goes to DRAIN for one cycle, which emits the final valid pair, then to FIN.
- FIN: done=1 and busy=0 for one cycle, then IDLE. A start arriving in FIN is ignored.
- The counter wraps to 0 on completion.
- Reset in any state: FSM goes to IDLE and outputs take their reset values. Memory already written stays written, so a partial CLEAR is allowed.
- Arithmetic: storage only, no modular reduction. Data passes through bit-exact and is signed.

Optional Feature:
KYBER_RAM_COLLISION_EN:
- Defined: adds output port collision (1 bit), a sticky flag. It sets on any IDLE cycle with we_1 & we_2 & (addr_1 == addr_2) and clears only on reset. Port-1-wins still applies.
- Undefined: the port and its logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package kyber_ram_pkg holds:
  - cmd encodings CMD_CLEAR = 0, CMD_DUMP = 1
  - FSM state enum (IDLE, CLEAR, DUMP, DRAIN, FIN)
  - default DATA_W/ADDR_W constants
- Sub-module kyber_ram_bank: plain read-first true-dual-port storage (no control), so it can infer block RAM.
- The sequencer and port muxing stay in kyber_poly_ram.

Test Plan:
1. Basic write/read: IDLE, write 777 @ addr 3 (port 1) and 555 @ addr 4 (port 2). Next cycle read 3 / 4 -> dout_1 = 777, dout_2 = 555, one cycle after the read address is applied.
2. Same-address write collision: both ports write addr 10, din_1 = -5, din_2 = 9 -> a later read of addr 10 returns -5. With KYBER_RAM_COLLISION_EN, collision=1 and stays set.
3. Read-during-write: port 1 writes 100 to addr 20 (holding 42) while port 2 reads addr 20 -> dout_2 = 42. A read on the next cycle gives 100.
4. DUMP order: preload mem[i] = i for i = 0..255, start with cmd=DUMP:
   - dump_valid high for 128 consecutive cycles
   - pair j gives dout_1 = 2j, dout_2 = 2j+1
   - done pulses one cycle after the last valid
   - busy low with done
5. CLEAR plus ignored inputs: fill with 0x7FFF, start CLEAR, and hold we_1=1, addr_1=0, din_1=123 and start=1 throughout -> done after 128 busy cycles. DUMP then returns all zeros, with no second CLEAR triggered.
6. Reset mid-DUMP: assert reset at pair 50 -> next cycle busy = dump_valid = done = 0 and dout = 0. A new DUMP restarts at pair 0 with memory intact.
